decode_seq_stage: RTL and testbench
===================================

# decode_seq_stage

Parametrised decode stage for the five-stage pipeline. It holds the register file (NREG × W) and the stack pointer register, and applies bubble insertion for branch flush and load-use stalls. Its micro-sequencer runs the multi-cycle RET, RTI and interrupt-entry sequences, with configurable step counts. It sits between the F/D and D/E buffers and feeds a combinational control decoder through `seq_kind`/`seq_step`, taking that decoder's output back on `ctrl_in`.

## Interface
- W, 16, data/register width
- NREG, 8, register count (power of 2); AW = log2(NREG)
- SP_W, 32, stack-pointer register width (≥ W)
- STACK_START, 2047, SP reset value
- CTRL_W, 26, control bundle width (EX+MEM+WB)
- OP_RET, 6'h1C / OP_RTI, 6'h1D, sequence-triggering opcodes
- RET_STEPS, 3 / RTI_STEPS, 4 / INT_STEPS, 3, sequence lengths in cycles (2..15)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- opcode  in  6  instruction opcode from F/D
- src, dst  in  AW  register read addresses
- ctrl_in  in  CTRL_W  control bundle from decoder
- interrupt  in  1  interrupt request pulse
- branch_taken  in  1  branch resolved taken (flush)
- load_use  in  1  load-use hazard detected
- wb_we, wb_addr[AW], wb_data[W]  in  write-back port
- sp_we  in  1, sp_wdata  in  W  SP update
- rsrc, rdst  out  W  register read data
- ctrl_out  out  CTRL_W  control to D/E buffer
- sp  out  W  SP low W bits
- fd_en, pc_en  out  1  F/D buffer and PC enables
- flush  out  1  flush F/D on sequence completion
- jump_sel  out  2  00 none, 01 INT vector, 10 RET, 11 RTI
- seq_kind  out  2  00 none, 01 INT, 10 RET, 11 RTI
- seq_step  out  4  current step index
- hazard_pop  out  1  high unless a RET/RTI sequence is active

## Operation
- Register file: posedge write when wb_we. Reads are combinational with write-first bypass: read address == wb_addr with wb_we returns wb_data. Reset clears all registers to 0.
- SP: SP_W-bit register, reset STACK_START. On sp_we, loads sp_wdata sign-extended to SP_W. `sp` = low W bits.
- bubble = branch_taken | load_use. When bubble, ctrl_out = 0; otherwise ctrl_out = ctrl_in.
- load_use additionally forces fd_en = pc_en = 0 that cycle.
- int_pend flag: set on interrupt, cleared when the INT sequence starts. It is held while a sequence runs or load_use is high.
- FSM states: IDLE, INT, RET, RTI; 4-bit step counter.
- Start, evaluated in IDLE, by priority:
  - int_pend (and !load_use) → INT.
  - Else opcode==OP_RET and !bubble → RET.
  - Else opcode==OP_RTI and !bubble → RTI.
- Start cycle = step 0, with seq_kind/seq_step driven combinationally. Each cycle the step increments. At step N-1 (N per kind) the FSM returns to IDLE.
- Steps 0..N-2: fd_en = pc_en = 0, jump_sel = 00, flush = 0.
- Step N-1: fd_en = pc_en = 1, flush = 1, jump_sel = kind code.
- branch_taken during RET/RTI steps ≥ 1: the sequence continues, but ctrl_out is bubbled that cycle. INT is never aborted.
- Interrupt arriving during a sequence is latched. INT starts the cycle after the sequence's final step.
- IDLE, no start: seq_kind = 00, seq_step = 0, jump_sel = 00, flush = 0. fd_en = pc_en = !load_use.

## Timing
- Reset values: state IDLE, step 0, int_pend 0, regs 0, SP STACK_START.
  - sp = STACK_START[W-1:0].
  - fd_en = pc_en = 1 (given load_use = 0).
  - flush = 0, jump_sel = 00, seq_kind = 00, hazard_pop = 1.
  - ctrl_out = ctrl_in, or 0 under bubble.
- Reset mid-sequence aborts to IDLE immediately (asynchronous).
- Sequence occupies exactly N cycles from the start cycle; PC resumes the cycle after step N-1.
- Interrupt pulse at cycle t in IDLE: int_pend set at edge t, INT step 0 at t+1.
- Register write at edge t is visible on reads in cycle t via bypass, and from the register afterwards.
- SP write at edge t is visible on `sp` from t+1.

## Test plan
- Reset, then write R3 = 16'hBEEF with src = 3 in the same cycle → rsrc = BEEF combinationally; after reset deassert, sp = 16'h07FF.
- opcode = OP_RET in IDLE, RET_STEPS = 3 → fd_en/pc_en low for 2 cycles, then cycle 3 gives jump_sel = 10 and flush = 1; hazard_pop low for all 3 cycles.
- Interrupt pulse during an RTI step 1 → RTI completes (4 cycles, jump_sel = 11), then INT runs 3 cycles ending with jump_sel = 01.
- opcode = OP_RET with branch_taken in IDLE → no sequence, ctrl_out = 0, seq_kind = 00.
- load_use with ctrl_in = all-ones → ctrl_out = 0 and fd_en = pc_en = 0; a simultaneous interrupt is deferred until load_use drops.
- sp_we with sp_wdata = 16'h8000 → internal SP = 32'hFFFF8000, sp = 16'h8000.

Source files
------------

// File: rtl/decode_seq_stage.sv
// Decode stage: register file, stack pointer, hazard bubbling and the
// multi-cycle RET / RTI / interrupt-entry micro-sequencer.
module decode_seq_stage #(
  parameter int          W           = 16,
  parameter int          NREG        = 8,
  parameter int          SP_W        = 32,
  parameter int          STACK_START = 2047,
  parameter int          CTRL_W      = 26,
  parameter logic [5:0]  OP_RET      = 6'h1C,
  parameter logic [5:0]  OP_RTI      = 6'h1D,
  parameter int          RET_STEPS   = 3,
  parameter int          RTI_STEPS   = 4,
  parameter int          INT_STEPS   = 3,
  localparam int         AW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        i_opcode,
  input  logic [AW-1:0]     i_src,
  input  logic [AW-1:0]     i_dst,
  input  logic [CTRL_W-1:0] i_ctrl_in,
  input  logic              i_interrupt,
  input  logic              i_branch_taken,
  input  logic              i_load_use,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [W-1:0]      i_wb_data,
  input  logic              i_sp_we,
  input  logic [W-1:0]      i_sp_wdata,
  output logic [W-1:0]      o_rsrc,
  output logic [W-1:0]      o_rdst,
  output logic [CTRL_W-1:0] o_ctrl_out,
  output logic [W-1:0]      o_sp,
  output logic              o_fd_en,
  output logic              o_pc_en,
  output logic              o_flush,
  output logic [1:0]        o_jump_sel,
  output logic [1:0]        o_seq_kind,
  output logic [3:0]        o_seq_step,
  output logic              o_hazard_pop
);

  // State encoding doubles as the seq_kind / jump_sel code.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INT  = 2'b01,
    S_RET  = 2'b10,
    S_RTI  = 2'b11
  } state_t;

  logic [W-1:0]    r_regs [NREG];
  logic [SP_W-1:0] r_sp;
  state_t          r_state;
  logic [3:0]      r_step;
  logic            r_int_pend;

  state_t          w_kind;
  state_t          w_state_next;
  logic [3:0]      w_step;
  logic [3:0]      w_step_next;
  logic [3:0]      w_last_step;
  logic            w_active;
  logic            w_last;
  logic            w_int_start;
  logic            w_bubble;

  // ---------------------------------------------------------------
  // Register file with write-first bypass on both read ports
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wb_we) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_rsrc = (i_wb_we && (i_wb_addr == i_src)) ? i_wb_data : r_regs[i_src];
  assign o_rdst = (i_wb_we && (i_wb_addr == i_dst)) ? i_wb_data : r_regs[i_dst];

  // ---------------------------------------------------------------
  // Stack pointer: wide register, loaded sign-extended
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= SP_W'(STACK_START);
    end else if (i_sp_we) begin
      r_sp <= SP_W'($signed(i_sp_wdata));
    end
  end

  assign o_sp = r_sp[W-1:0];

  generate
    if (SP_W > W) begin : g_sp_hi
      // Upper SP bits are architectural state with no port of their own.
      logic w_unused_sp_hi;
      assign w_unused_sp_hi = ^r_sp[SP_W-1:W];
    end
  endgenerate

  // ---------------------------------------------------------------
  // Hazard bubbling
  // ---------------------------------------------------------------
  assign w_bubble   = i_branch_taken | i_load_use;
  assign o_ctrl_out = w_bubble ? '0 : i_ctrl_in;

  // ---------------------------------------------------------------
  // Pending-interrupt latch
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_pend <= 1'b0;
    end else if (i_interrupt) begin
      r_int_pend <= 1'b1;
    end else if (w_int_start) begin
      r_int_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Micro-sequencer: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
    end
  end

  // ---------------------------------------------------------------
  // Micro-sequencer: start decision, step tracking and outputs
  // ---------------------------------------------------------------
  always_comb begin
    w_kind      = S_IDLE;
    w_step      = '0;
    w_int_start = 1'b0;

    // The start cycle is step 0 of the sequence, so the active kind is
    // resolved combinationally from IDLE.
    case (r_state)
      S_IDLE: begin
        if (r_int_pend && !i_load_use) begin
          w_kind      = S_INT;
          w_int_start = 1'b1;
        end else if ((i_opcode == OP_RET) && !w_bubble) begin
          w_kind = S_RET;
        end else if ((i_opcode == OP_RTI) && !w_bubble) begin
          w_kind = S_RTI;
        end
      end
      default: begin
        w_kind = r_state;
        w_step = r_step;
      end
    endcase
  end

  always_comb begin
    w_last_step = 4'd0;
    case (w_kind)
      S_INT:   w_last_step = 4'(INT_STEPS - 1);
      S_RET:   w_last_step = 4'(RET_STEPS - 1);
      S_RTI:   w_last_step = 4'(RTI_STEPS - 1);
      default: w_last_step = 4'd0;
    endcase
  end

  assign w_active = (w_kind != S_IDLE);
  assign w_last   = w_active && (w_step == w_last_step);

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    if (w_active) begin
      if (w_last) begin
        w_state_next = S_IDLE;
        w_step_next  = '0;
      end else begin
        w_state_next = w_kind;
        w_step_next  = w_step + 4'd1;
      end
    end
  end

  always_comb begin
    o_fd_en      = 1'b1;
    o_pc_en      = 1'b1;
    o_flush      = 1'b0;
    o_jump_sel   = 2'b00;
    o_seq_kind   = w_kind;
    o_seq_step   = w_step;
    o_hazard_pop = !((w_kind == S_RET) || (w_kind == S_RTI));

    if (w_active && !w_last) begin
      o_fd_en = 1'b0;
      o_pc_en = 1'b0;
    end
    if (w_last) begin
      o_flush    = 1'b1;
      o_jump_sel = w_kind;
    end
    // A load-use stall freezes fetch regardless of sequencer state.
    if (i_load_use) begin
      o_fd_en = 1'b0;
      o_pc_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_seq_stage.sv
// Directed bench for decode_seq_stage: register bypass, SP, bubbles and the
// RET / RTI / INT micro-sequences, checked with immediate assertions.
module tb_decode_seq_stage;

  localparam int W      = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;
  localparam int CTRL_W = 26;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        opcode;
  logic [AW-1:0]     src, dst;
  logic [CTRL_W-1:0] ctrl_in;
  logic              interrupt, branch_taken, load_use;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [W-1:0]      wb_data;
  logic              sp_we;
  logic [W-1:0]      sp_wdata;
  logic [W-1:0]      rsrc, rdst;
  logic [CTRL_W-1:0] ctrl_out;
  logic [W-1:0]      sp;
  logic              fd_en, pc_en, flush;
  logic [1:0]        jump_sel, seq_kind;
  logic [3:0]        seq_step;
  logic              hazard_pop;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_seq_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_opcode       (opcode),
    .i_src          (src),
    .i_dst          (dst),
    .i_ctrl_in      (ctrl_in),
    .i_interrupt    (interrupt),
    .i_branch_taken (branch_taken),
    .i_load_use     (load_use),
    .i_wb_we        (wb_we),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .i_sp_we        (sp_we),
    .i_sp_wdata     (sp_wdata),
    .o_rsrc         (rsrc),
    .o_rdst         (rdst),
    .o_ctrl_out     (ctrl_out),
    .o_sp           (sp),
    .o_fd_en        (fd_en),
    .o_pc_en        (pc_en),
    .o_flush        (flush),
    .o_jump_sel     (jump_sel),
    .o_seq_kind     (seq_kind),
    .o_seq_step     (seq_step),
    .o_hazard_pop   (hazard_pop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [1:0] kind, input logic [3:0] step,
                         input logic en, input logic fl, input logic [1:0] jump,
                         input logic hp);
    chk({tag, ".kind"}, 32'(seq_kind), 32'(kind));
    chk({tag, ".step"}, 32'(seq_step), 32'(step));
    chk({tag, ".fd_en"}, 32'(fd_en), 32'(en));
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(en));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".jump"}, 32'(jump_sel), 32'(jump));
    chk({tag, ".hpop"}, 32'(hazard_pop), 32'(hp));
    $display("step %s kind=%0d step=%0d fd=%0b flush=%0b jump=%0d hpop=%0b",
             tag, seq_kind, seq_step, fd_en, flush, jump_sel, hazard_pop);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    opcode       = 6'h00;
    src          = 3'd3;
    dst          = 3'd0;
    ctrl_in      = 26'h2ABCDEF;
    interrupt    = 1'b0;
    branch_taken = 1'b0;
    load_use     = 1'b0;
    wb_we        = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    sp_we        = 1'b0;
    sp_wdata     = '0;

    // Reset state
    #12;
    chk("rst.sp", 32'(sp), 32'h07FF);
    chk("rst.ctrl", 32'(ctrl_out), 32'h2ABCDEF);
    chk("rst.rsrc", 32'(rsrc), 32'h0);
    chk_seq("rst", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    // Write R3 with same-cycle read through bypass
    rst_n   = 1'b1;
    wb_we   = 1'b1;
    wb_addr = 3'd3;
    wb_data = 16'hBEEF;
    #1;
    chk("wb.bypass", 32'(rsrc), 32'hBEEF);
    chk("wb.rdst_other", 32'(rdst), 32'h0);
    $display("txn regwrite R3=BEEF rsrc=%h", rsrc);
    tick();
    wb_we = 1'b0;
    #1;
    chk("wb.stored", 32'(rsrc), 32'hBEEF);

    // RET: 3 cycles, branch during step 1 only bubbles ctrl_out
    opcode = 6'h1C;
    #1;
    chk_seq("ret0", 2'b10, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    opcode       = 6'h00;
    branch_taken = 1'b1;
    #1;
    chk_seq("ret1", 2'b10, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("ret1.ctrl", 32'(ctrl_out), 32'h0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk_seq("ret2", 2'b10, 4'd2, 1'b1, 1'b1, 2'b10, 1'b0);
    chk("ret2.ctrl", 32'(ctrl_out), 32'h2ABCDEF);
    tick();
    #1;
    chk_seq("ret_done", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    // RTI with an interrupt during step 1, then INT follows
    opcode = 6'h1D;
    #1;
    chk_seq("rti0", 2'b11, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    opcode    = 6'h00;
    interrupt = 1'b1;
    #1;
    chk_seq("rti1", 2'b11, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    interrupt = 1'b0;
    #1;
    chk_seq("rti2", 2'b11, 4'd2, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    #1;
    chk_seq("rti3", 2'b11, 4'd3, 1'b1, 1'b1, 2'b11, 1'b0);
    tick();
    #1;
    chk_seq("int0", 2'b01, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    #1;
    chk_seq("int1", 2'b01, 4'd1, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    #1;
    chk_seq("int2", 2'b01, 4'd2, 1'b1, 1'b1, 2'b01, 1'b1);
    tick();
    #1;
    chk_seq("int_done", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    // RET opcode under branch_taken in IDLE: no sequence, bubbled control
    opcode       = 6'h1C;
    branch_taken = 1'b1;
    #1;
    chk("brret.ctrl", 32'(ctrl_out), 32'h0);
    chk_seq("brret", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    tick();
    opcode       = 6'h00;
    branch_taken = 1'b0;
    #1;
    chk_seq("brret_after", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    // load_use stalls and bubbles, and defers a simultaneous interrupt
    ctrl_in   = '1;
    load_use  = 1'b1;
    interrupt = 1'b1;
    #1;
    chk("lu0.ctrl", 32'(ctrl_out), 32'h0);
    chk_seq("lu0", 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    interrupt = 1'b0;
    #1;
    chk_seq("lu1", 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    load_use = 1'b0;
    #1;
    chk("lu_int0.ctrl", 32'(ctrl_out), 32'h3FFFFFF);
    chk_seq("lu_int0", 2'b01, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    #1;
    chk_seq("lu_int1", 2'b01, 4'd1, 1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    #1;
    chk_seq("lu_int2", 2'b01, 4'd2, 1'b1, 1'b1, 2'b01, 1'b1);
    tick();
    #1;
    chk_seq("lu_done", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    // SP load, sign-extended, visible after the edge
    sp_we    = 1'b1;
    sp_wdata = 16'h8000;
    #1;
    chk("sp.before", 32'(sp), 32'h07FF);
    tick();
    sp_we = 1'b0;
    #1;
    chk("sp.low", 32'(sp), 32'h8000);
    chk("sp.wide", dut.r_sp, 32'hFFFF8000);
    $display("txn sp_write 8000 sp=%h wide=%h", sp, dut.r_sp);

    // Asynchronous reset in the middle of a RET sequence
    opcode = 6'h1C;
    #1;
    chk_seq("rret0", 2'b10, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    opcode = 6'h00;
    #1;
    chk_seq("rret1", 2'b10, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_seq("rret_rst", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("rret_rst.sp", 32'(sp), 32'h07FF);
    chk("rret_rst.rsrc", 32'(rsrc), 32'h0);
    rst_n = 1'b1;
    tick();
    #1;
    chk_seq("rret_after", 2'b00, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
